pll_lock_ctrl: RTL and testbench
================================

Name: pll_lock_ctrl

Overview:
Power-up and lock-supervision sequencer for the 61.44 MHz audio PLL (100 MHz reference in).
- Runs on the PLL reference clock and drives the PLL reset.
- Qualifies the PLL locked output, with timeout and bounded retries.
- Produces a registered ready flag; the audio-domain reset logic uses it to release reset.
- Detects loss of lock in operation and re-sequences the PLL automatically.

Parameters:
RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 100000, refclk cycles allowed from PLL reset release to qualified lock (1 ms at 100 MHz)
LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before ready (>=1, < LOCK_TIMEOUT)
MAX_RETRIES, 3, retries after the first failed attempt before entering FAIL

Ports:
refclk  in  1  100 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
restart  in  1  one-cycle pulse; leaves FAIL, ignored in other states
pll_rst  out  1  reset to PLL, active-high
ready  out  1  PLL qualified locked; downstream may leave reset
fail  out  1  retries exhausted
state  out  3  current state code
retry_cnt  out  $clog2(MAX_RETRIES+1)  retries used in the current sequence
loss_cnt  out  8  saturating count of lock losses while in RUN

Behaviour:
- Clocking and reset: one clock, refclk. rst is synchronous and active-high. All outputs are registered.
- Values while rst is high: state=RESET_PLL, pll_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, all counters 0, synchronizer flops 0.
- Synchronization: pll_locked passes through a 2-flop synchronizer to give lk_s, adding 2 cycles of latency. The FSM uses only lk_s.
- State codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- Counters:
  - rcnt: counts in RESET_PLL.
  - tcnt: timeout counter; runs through WAIT_LOCK and STABLE; cleared only on entry to WAIT_LOCK from RESET_PLL.
  - scnt: stability counter; cleared on entry to STABLE.
- RESET_PLL: pll_rst=1, ready=0. When rcnt==RST_CYCLES-1, go to WAIT_LOCK; pll_rst=0 from the next cycle.
- WAIT_LOCK:
  - lk_s=1: go to STABLE.
  - Else, when tcnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES, go to FAIL; otherwise retry_cnt+=1 and go to RESET_PLL.
  - lk_s=1 and timeout in the same cycle: lock wins.
- STABLE:
  - lk_s=0: return to WAIT_LOCK with tcnt NOT cleared. This bounds lock chatter.
  - lk_s=1 and scnt==LOCK_STABLE-1: go to RUN.
  - Timeout applies exactly as in WAIT_LOCK.
  - Priority: lk_s=0 > stable completion > timeout.
- RUN:
  - ready=1 starting the first cycle in RUN.
  - lk_s=0: go to RESET_PLL. ready=0 and pll_rst=1 take effect on the following cycle. loss_cnt increments, saturating at 255. retry_cnt clears to 0.
- FAIL: pll_rst=1, fail=1, ready=0.
  - restart=1: go to RESET_PLL with retry_cnt=0 and fail=0 on the next cycle.
  - Otherwise hold until rst.
- rst mid-operation (any state, including RUN or FAIL): immediate return to reset values on the next edge. loss_cnt clears.
- Worst-case time to ready: 2 + RST_CYCLES + LOCK_STABLE cycles after rst falls, given pll_locked already high.

Decomposition:
- Package pll_ctrl_pkg:
  - state enum (3-bit, codes above)
  - LOSS_CNT_W=8
  - function for counter widths: $clog2 of the max of the parameters, minimum 1
- One sub-module: sync_2ff (generic 2-flop single-bit synchronizer, reset to 0, synchronous active-high rst). It is reused by other clock-crossing blocks.
- FSM and counters stay in pll_lock_ctrl.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRIES=2.
1. Nominal: pll_locked=1 from cycle 0, rst released at cycle 0 -> pll_rst high cycles 0-3, ready=1 at cycle 2+4+8=14 (±1 edge per spec above), state=3, fail=0.
2. Timeout and retry: pll_locked=0 throughout -> three pll_rst pulses of 4 cycles each, retry_cnt steps 0→1→2, then FAIL with fail=1, state=4, pll_rst=1; restart pulse -> state=0, retry_cnt=0, fail=0.
3. Chatter: pll_locked toggles every 5 cycles -> never reaches RUN; timeout fires 50 cycles after the first WAIT_LOCK entry, not restarted by each drop; retry_cnt=1.
4. Loss of lock: in RUN, drop pll_locked for 1 cycle -> ready falls 3 cycles later, loss_cnt=1, new pll_rst pulse of 4 cycles, ready returns after requalification; repeat 260 times -> loss_cnt=255.
5. Reset mid-sequence: assert rst for 1 cycle while in STABLE and while in FAIL -> next cycle all outputs at reset values, loss_cnt=0.
6. Simultaneous events: lk_s rises exactly at tcnt=49 -> enters STABLE, retry_cnt unchanged; lk_s falls at scnt=7 -> WAIT_LOCK, not RUN.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared types and helpers for the PLL lock sequencer:
//               state encoding, loss counter width, counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    // Width needed to count 0..max(a,b,c)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop single-bit synchronizer. Both stages clear
//               to 0 under synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift of the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_ctrl
// Description : Power-up and lock-supervision sequencer for the audio PLL.
//               Drives the PLL reset, qualifies lock with a timeout and a
//               bounded retry count, and re-sequences on loss of lock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    input  logic                             restart,
    output logic                             pll_rst,
    output logic                             ready,
    output logic                             fail,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [7:0]                       loss_cnt
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]      C_RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      C_STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0]      C_RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [LOSS_CNT_W-1:0] C_LOSS_MAX = '1;

    logic lk_s;

    pll_state_e             state_q,   state_d;
    logic [CNT_W-1:0]       rcnt_q,    rcnt_d;
    logic [CNT_W-1:0]       tcnt_q,    tcnt_d;
    logic [CNT_W-1:0]       scnt_q,    scnt_d;
    logic [RTY_W-1:0]       retry_q,   retry_d;
    logic [LOSS_CNT_W-1:0]  loss_q,    loss_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q,   ready_d;
    logic                   fail_q,    fail_d;

    logic w_tmo;
    logic w_tcnt_inc;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (lk_s)
    );

    // tcnt saturates on its last value, so a timeout deferred by a
    // higher-priority event (lock, or a drop in STABLE) still fires the
    // next time the FSM is free to honour it.
    assign w_tmo      = (tcnt_q == C_TMO_LAST);
    assign w_tcnt_inc = (tcnt_q <  C_TMO_LAST);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        tcnt_d  = tcnt_q;
        scnt_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            ST_RESET_PLL: begin
                tcnt_d = '0;
                if (rcnt_q == C_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_tcnt_inc) tcnt_d = tcnt_q + 1'b1;
                if (lk_s) begin
                    state_d = ST_STABLE;
                end else if (w_tmo) begin
                    if (retry_q == C_RTY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_RESET_PLL;
                    end
                end
            end
            ST_STABLE: begin
                if (w_tcnt_inc) tcnt_d = tcnt_q + 1'b1;
                scnt_d = scnt_q + 1'b1;
                // Drop returns to WAIT_LOCK keeping tcnt, bounding chatter.
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (scnt_q == C_STB_LAST) begin
                    state_d = ST_RUN;
                end else if (w_tmo) begin
                    if (retry_q == C_RTY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_RESET_PLL;
                    end
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                    if (loss_q != C_LOSS_MAX) loss_d = loss_q + 1'b1;
                end
            end
            ST_FAIL: begin
                if (restart) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        // Outputs follow the state being entered so they are registered
        // yet aligned with the state code.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            rcnt_q    <= '0;
            tcnt_q    <= '0;
            scnt_q    <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
            scnt_q    <= scnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_ctrl
// Description : Directed self-checking bench for pll_lock_ctrl with
//               RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRIES=2.
//               t counts refclk edges since rst was last released; outputs
//               are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 50;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart    = 1'b0;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int k        = 0;
    bit saw_run  = 1'b0;

    always #5 refclk = ~refclk;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    // One-cycle synchronous reset; t restarts at the release point.
    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_loss"}, 32'(loss_cnt), 0);
    endtask

    initial begin
        // Power-on reset with the PLL already reporting lock.
        pll_locked = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("por");
        rst = 1'b0;
        t   = 0;

        // Nominal bring-up: pll_rst for 4 cycles, sync 2, stable 8.
        run_to(3);
        chk("nom_rst_hi", 32'(pll_rst), 1);
        chk("nom_st_reset", 32'(state), 0);
        run_to(4);
        chk("nom_rst_lo", 32'(pll_rst), 0);
        chk("nom_st_wait", 32'(state), 1);
        run_to(5);
        chk("nom_st_stable", 32'(state), 2);
        run_to(12);
        chk("nom_not_ready", 32'(ready), 0);
        run_to(13);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_st_run", 32'(state), 3);
        chk("nom_fail", 32'(fail), 0);

        // Lock drops exactly when scnt reaches its last value: back to WAIT.
        pulse_rst();
        chk("rst_in_run_state", 32'(state), 0);
        run_to(10);
        pll_locked = 1'b0;
        run_to(12);
        chk("sim_scnt7_stable", 32'(state), 2);
        run_to(13);
        chk("sim_scnt7_wait", 32'(state), 1);
        chk("sim_scnt7_ready", 32'(ready), 0);

        // Lock arrives exactly at tcnt=49: lock beats timeout.
        pll_locked = 1'b0;
        pulse_rst();
        run_to(51);
        pll_locked = 1'b1;
        run_to(53);
        chk("sim_tmo_wait", 32'(state), 1);
        run_to(54);
        chk("sim_tmo_stable", 32'(state), 2);
        chk("sim_tmo_retry", 32'(retry_cnt), 0);

        // Chatter: lock toggles every 5 cycles; timeout still at t=54.
        pll_locked = 1'b0;
        pulse_rst();
        saw_run = 1'b0;
        while (t < 54) begin
            pll_locked = ((t / 5) % 2) == 1;
            tick();
            if (state == 3'd3) saw_run = 1'b1;
            if (t == 53) begin
                chk("chat_pre_state", 32'(state), 1);
                chk("chat_pre_retry", 32'(retry_cnt), 0);
            end
        end
        chk("chat_tmo_state", 32'(state), 0);
        chk("chat_tmo_retry", 32'(retry_cnt), 1);
        chk("chat_tmo_pll_rst", 32'(pll_rst), 1);
        chk("chat_no_run", 32'(saw_run), 0);

        // Timeout and retries to FAIL, then restart.
        pll_locked = 1'b0;
        pulse_rst();
        run_to(53);
        chk("tmo_retry0", 32'(retry_cnt), 0);
        run_to(54);
        chk("tmo_retry1", 32'(retry_cnt), 1);
        chk("tmo_st_reset1", 32'(state), 0);
        run_to(57);
        chk("tmo_pulse1_hi", 32'(pll_rst), 1);
        run_to(58);
        chk("tmo_pulse1_lo", 32'(pll_rst), 0);
        run_to(108);
        chk("tmo_retry2", 32'(retry_cnt), 2);
        chk("tmo_pulse2_hi", 32'(pll_rst), 1);
        run_to(161);
        chk("tmo_last_wait", 32'(state), 1);
        run_to(162);
        chk("fail_state", 32'(state), 4);
        chk("fail_flag", 32'(fail), 1);
        chk("fail_pll_rst", 32'(pll_rst), 1);
        chk("fail_retry", 32'(retry_cnt), 2);
        run_to(163);
        chk("fail_hold", 32'(state), 4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_state", 32'(state), 0);
        chk("restart_retry", 32'(retry_cnt), 0);
        chk("restart_fail", 32'(fail), 0);
        chk("restart_pll_rst", 32'(pll_rst), 1);
        run_to(326);
        chk("fail2_state", 32'(state), 4);
        pulse_rst();
        chk_reset("rst_in_fail");

        // One timeout, then lock: RUN with retry_cnt=1, cleared on loss.
        pll_locked = 1'b0;
        pulse_rst();
        run_to(54);
        chk("loss_pre_retry", 32'(retry_cnt), 1);
        pll_locked = 1'b1;
        run_to(66);
        chk("loss_pre_notready", 32'(ready), 0);
        run_to(67);
        chk("loss_run_ready", 32'(ready), 1);
        chk("loss_run_retry", 32'(retry_cnt), 1);
        run_to(70);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(72);
        chk("loss_ready_held", 32'(ready), 1);
        run_to(73);
        chk("loss_ready_fall", 32'(ready), 0);
        chk("loss_pll_rst", 32'(pll_rst), 1);
        chk("loss_cnt1", 32'(loss_cnt), 1);
        chk("loss_retry_clr", 32'(retry_cnt), 0);
        run_to(76);
        chk("loss_pulse_hi", 32'(pll_rst), 1);
        run_to(77);
        chk("loss_pulse_lo", 32'(pll_rst), 0);
        run_to(85);
        chk("loss_requal_lo", 32'(ready), 0);
        run_to(86);
        chk("loss_requal_hi", 32'(ready), 1);

        // 259 more losses: loss_cnt saturates at 255.
        for (int i = 1; i < 260; i++) begin
            k = t;
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            run_to(k + 16);
            if (i == 253) chk("loss_cnt254", 32'(loss_cnt), 254);
            if (i == 254) chk("loss_cnt255", 32'(loss_cnt), 255);
        end
        chk("loss_sat", 32'(loss_cnt), 255);
        chk("loss_final_run", 32'(state), 3);
        chk("loss_final_ready", 32'(ready), 1);

        // Reset while in STABLE clears everything, including loss_cnt.
        k = t;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(k + 9);
        chk("rst_stb_pre_state", 32'(state), 2);
        pulse_rst();
        chk_reset("rst_in_stable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
